// File: rtl/arb_mux_reg.sv
// N-to-1 bus multiplexer with one registered output stage and valid/ready
// handshakes; the source is picked by external select, round-robin or fixed priority.
module arb_mux_reg #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    parameter  int MODE   = 0,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1'b1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] rr_q, rr_d;

    logic             load_s;
    logic             has_grant_s;
    logic [SEL_W-1:0] grant_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;

    int               dist_v;
    int               best_v;

    // Grant selection for the configured arbitration mode.
    always_comb begin
        has_grant_s = 1'b0;
        grant_s     = SEL_ZERO;
        dist_v      = 0;
        best_v      = NUM_CH;
        case (MODE)
            0: begin
                // An out-of-range sel matches no channel, so it simply yields no grant.
                for (int i = 0; i < NUM_CH; i++) begin
                    if ((sel == i[SEL_W-1:0]) && in_valid[i]) begin
                        has_grant_s = 1'b1;
                        grant_s     = i[SEL_W-1:0];
                    end else begin
                        has_grant_s = has_grant_s;
                    end
                end
            end
            1: begin
                // Closest valid channel at or after rr_q, measured with wrap-around.
                for (int i = 0; i < NUM_CH; i++) begin
                    dist_v = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + NUM_CH - int'(rr_q));
                    if (in_valid[i] && (dist_v < best_v)) begin
                        best_v      = dist_v;
                        has_grant_s = 1'b1;
                        grant_s     = i[SEL_W-1:0];
                    end else begin
                        best_v = best_v;
                    end
                end
            end
            2: begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        has_grant_s = 1'b1;
                        grant_s     = i[SEL_W-1:0];
                    end else begin
                        has_grant_s = has_grant_s;
                    end
                end
            end
            default: begin
                has_grant_s = 1'b0;
                grant_s     = SEL_ZERO;
            end
        endcase
    end

    assign load_s = !valid_q || out_ready;
    assign xfer_s = rst_n && load_s && has_grant_s;

    // Data mux for the granted channel and the one-hot ready vector.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        in_ready   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_s == i[SEL_W-1:0]) begin
                sel_data_s  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer_s;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (xfer_s) begin
            data_d  = sel_data_s;
            ch_d    = grant_s;
            valid_d = 1'b1;
            if (MODE == 1) begin
                rr_d = (grant_s == LAST_CH) ? SEL_ZERO : (grant_s + SEL_ONE);
            end else begin
                rr_d = rr_q;
            end
        end else if (load_s) begin
            // Drained without refill: payload keeps its last value.
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= {WIDTH{1'b0}};
            ch_q    <= SEL_ZERO;
            valid_q <= 1'b0;
            rr_q    <= SEL_ZERO;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: external-select (4 and 5 channels),
// round-robin and fixed-priority instances share one clock and reset.
module tb_arb_mux_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pas = 0;
    int tot = 0;

    // MODE0, 4 channels
    logic [31:0] d0; logic [3:0] v0, r0; logic [1:0] s0, ch0; logic [7:0] o0; logic ov0, or0;
    // MODE0, 5 channels
    logic [39:0] d5; logic [4:0] v5, r5; logic [2:0] s5, ch5; logic [7:0] o5; logic ov5, or5;
    // MODE1, 4 channels
    logic [31:0] d1; logic [3:0] v1, r1; logic [1:0] s1, ch1; logic [7:0] o1; logic ov1, or1;
    // MODE2, 4 channels
    logic [31:0] d2; logic [3:0] v2, r2; logic [1:0] s2, ch2; logic [7:0] o2; logic ov2, or2;

    arb_mux_reg #(.WIDTH(8), .NUM_CH(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
        .out_data(o0), .out_valid(ov0), .out_ready(or0), .out_ch(ch0));
    arb_mux_reg #(.WIDTH(8), .NUM_CH(5), .MODE(0)) u5 (
        .clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v5), .in_ready(r5), .sel(s5),
        .out_data(o5), .out_valid(ov5), .out_ready(or5), .out_ch(ch5));
    arb_mux_reg #(.WIDTH(8), .NUM_CH(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
        .out_data(o1), .out_valid(ov1), .out_ready(or1), .out_ch(ch1));
    arb_mux_reg #(.WIDTH(8), .NUM_CH(4), .MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
        .out_data(o2), .out_valid(ov2), .out_ready(or2), .out_ch(ch2));

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 4'hF; v1 = 4'hF; v2 = 4'hF; v5 = 5'h1F;
        or0 = 1'b1; or1 = 1'b1; or2 = 1'b1; or5 = 1'b1;
        d0 = 32'h01020304; d1 = 32'h01020304; d2 = 32'h01020304; d5 = 40'h0102030405;
        s0 = 2'd0; s1 = 2'd0; s2 = 2'd0; s5 = 3'd0;
        #1;
        tot++; if (r0 !== 4'b0000) $display("FAIL rst_ready_m0 got=%b exp=%b", r0, 4'b0000); else pas++;
        tot++; if (r1 !== 4'b0000) $display("FAIL rst_ready_m1 got=%b exp=%b", r1, 4'b0000); else pas++;
        tot++; if (r2 !== 4'b0000) $display("FAIL rst_ready_m2 got=%b exp=%b", r2, 4'b0000); else pas++;
        tot++; if (r5 !== 5'b00000) $display("FAIL rst_ready_n5 got=%b exp=%b", r5, 5'b00000); else pas++;
        @(posedge clk); #1;
        tot++; if (ov1 !== 1'b0) $display("FAIL rst_valid got=%b exp=%b", ov1, 1'b0); else pas++;
        tot++; if (o1 !== 8'h00) $display("FAIL rst_data got=%h exp=%h", o1, 8'h00); else pas++;
        tot++; if (ch1 !== 2'd0) $display("FAIL rst_ch got=%0d exp=%0d", ch1, 0); else pas++;
        tot++; if (ov0 !== 1'b0) $display("FAIL rst_valid_m0 got=%b exp=%b", ov0, 1'b0); else pas++;
        rst_n = 1'b1;
        v0 = 4'h0; v1 = 4'h0; v2 = 4'h0; v5 = 5'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_mode0();
        s0 = 2'd2; d0 = {8'h11, 8'hA5, 8'h22, 8'h33}; v0 = 4'b0101; or0 = 1'b1;
        s5 = 3'd6; d5 = 40'h0102030405; v5 = 5'h1F; or5 = 1'b1;
        #1;
        tot++; if (r0 !== 4'b0100) $display("FAIL m0_ready got=%b exp=%b", r0, 4'b0100); else pas++;
        tot++; if (r5 !== 5'b00000) $display("FAIL m0_oor_ready got=%b exp=%b", r5, 5'b00000); else pas++;
        @(posedge clk); #1;
        tot++; if (o0 !== 8'hA5) $display("FAIL m0_data got=%h exp=%h", o0, 8'hA5); else pas++;
        tot++; if (ch0 !== 2'd2) $display("FAIL m0_ch got=%0d exp=%0d", ch0, 2); else pas++;
        tot++; if (ov0 !== 1'b1) $display("FAIL m0_valid got=%b exp=%b", ov0, 1'b1); else pas++;
        tot++; if (ov5 !== 1'b0) $display("FAIL m0_oor_valid got=%b exp=%b", ov5, 1'b0); else pas++;
        v0 = 4'b1011; v5 = 5'h00;
        #1;
        tot++; if (r0 !== 4'b0000) $display("FAIL m0_nogrant_ready got=%b exp=%b", r0, 4'b0000); else pas++;
        @(posedge clk); #1;
        tot++; if (ov0 !== 1'b0) $display("FAIL m0_drain_valid got=%b exp=%b", ov0, 1'b0); else pas++;
        tot++; if (o0 !== 8'hA5) $display("FAIL m0_drain_data got=%h exp=%h", o0, 8'hA5); else pas++;
        v0 = 4'h0;
    endtask

    task automatic test_back_pressure();
        s0 = 2'd1; d0 = {8'h00, 8'h00, 8'h3C, 8'h00}; v0 = 4'b0010; or0 = 1'b1;
        @(posedge clk); #1;
        tot++; if (o0 !== 8'h3C) $display("FAIL bp_load got=%h exp=%h", o0, 8'h3C); else pas++;
        or0 = 1'b0; v0 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            s0 = 2'(k);
            d0 = 32'(k + 1) * 32'h01010101;
            #1;
            tot++; if (r0 !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=%b", k, r0, 4'b0000); else pas++;
            @(posedge clk); #1;
            tot++; if (o0 !== 8'h3C) $display("FAIL bp_data[%0d] got=%h exp=%h", k, o0, 8'h3C); else pas++;
            tot++; if (ch0 !== 2'd1) $display("FAIL bp_ch[%0d] got=%0d exp=%0d", k, ch0, 1); else pas++;
            tot++; if (ov0 !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=%b", k, ov0, 1'b1); else pas++;
        end
        or0 = 1'b1; s0 = 2'd3; d0 = {8'hC3, 24'h000000};
        #1;
        tot++; if (r0 !== 4'b1000) $display("FAIL bp_release_ready got=%b exp=%b", r0, 4'b1000); else pas++;
        @(posedge clk); #1;
        tot++; if (o0 !== 8'hC3) $display("FAIL bp_release_data got=%h exp=%h", o0, 8'hC3); else pas++;
        tot++; if (ch0 !== 2'd3) $display("FAIL bp_release_ch got=%0d exp=%0d", ch0, 3); else pas++;
        tot++; if (ov0 !== 1'b1) $display("FAIL bp_release_valid got=%b exp=%b", ov0, 1'b1); else pas++;
        v0 = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int seq_a [6] = '{0, 1, 2, 3, 0, 1};
        int seq_b [4] = '{3, 1, 3, 1};
        int seq_c [2] = '{2, 3};
        d1 = {8'h44, 8'h33, 8'h22, 8'h11}; v1 = 4'hF; or1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            tot++; if (ch1 !== 2'(seq_a[k])) $display("FAIL rr_all_ch[%0d] got=%0d exp=%0d", k, ch1, seq_a[k]); else pas++;
            tot++; if (o1 !== 8'(8'h11 * (seq_a[k] + 1))) $display("FAIL rr_all_data[%0d] got=%h exp=%h", k, o1, 8'(8'h11 * (seq_a[k] + 1))); else pas++;
        end
        v1 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tot++; if (ch1 !== 2'(seq_b[k])) $display("FAIL rr_odd_ch[%0d] got=%0d exp=%0d", k, ch1, seq_b[k]); else pas++;
        end
        v1 = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tot++; if (ov1 !== 1'b0) $display("FAIL rr_idle_valid[%0d] got=%b exp=%b", k, ov1, 1'b0); else pas++;
        end
        tot++; if (ch1 !== 2'd1) $display("FAIL rr_idle_ch got=%0d exp=%0d", ch1, 1); else pas++;
        tot++; if (o1 !== 8'h22) $display("FAIL rr_idle_data got=%h exp=%h", o1, 8'h22); else pas++;
        v1 = 4'hF;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tot++; if (ch1 !== 2'(seq_c[k])) $display("FAIL rr_resume_ch[%0d] got=%0d exp=%0d", k, ch1, seq_c[k]); else pas++;
        end
        v1 = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        d2 = {8'hD3, 8'h00, 8'h00, 8'hD0}; v2 = 4'b1001; or2 = 1'b1;
        #1;
        tot++; if (r2 !== 4'b0001) $display("FAIL fp_ready got=%b exp=%b", r2, 4'b0001); else pas++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tot++; if (ch2 !== 2'd0) $display("FAIL fp_ch[%0d] got=%0d exp=%0d", k, ch2, 0); else pas++;
            tot++; if (o2 !== 8'hD0) $display("FAIL fp_data[%0d] got=%h exp=%h", k, o2, 8'hD0); else pas++;
        end
        v2 = 4'b1000;
        #1;
        tot++; if (r2 !== 4'b1000) $display("FAIL fp_drop_ready got=%b exp=%b", r2, 4'b1000); else pas++;
        @(posedge clk); #1;
        tot++; if (ch2 !== 2'd3) $display("FAIL fp_drop_ch got=%0d exp=%0d", ch2, 3); else pas++;
        tot++; if (o2 !== 8'hD3) $display("FAIL fp_drop_data got=%h exp=%h", o2, 8'hD3); else pas++;
        v2 = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        d1 = {8'h44, 8'h33, 8'h22, 8'h11}; v1 = 4'b0010; or1 = 1'b1;
        @(posedge clk); #1;
        tot++; if (ch1 !== 2'd1) $display("FAIL rm_setup_ch got=%0d exp=%0d", ch1, 1); else pas++;
        or1 = 1'b0; v1 = 4'hF;
        #1;
        tot++; if (r1 !== 4'b0000) $display("FAIL rm_hold_ready got=%b exp=%b", r1, 4'b0000); else pas++;
        @(posedge clk); #1;
        tot++; if (ov1 !== 1'b1) $display("FAIL rm_hold_valid got=%b exp=%b", ov1, 1'b1); else pas++;
        rst_n = 1'b0;
        #1;
        tot++; if (r1 !== 4'b0000) $display("FAIL rm_rst_ready got=%b exp=%b", r1, 4'b0000); else pas++;
        @(posedge clk); #1;
        tot++; if (ov1 !== 1'b0) $display("FAIL rm_rst_valid got=%b exp=%b", ov1, 1'b0); else pas++;
        tot++; if (o1 !== 8'h00) $display("FAIL rm_rst_data got=%h exp=%h", o1, 8'h00); else pas++;
        rst_n = 1'b1; or1 = 1'b1;
        #1;
        tot++; if (r1 !== 4'b0001) $display("FAIL rm_first_ready got=%b exp=%b", r1, 4'b0001); else pas++;
        @(posedge clk); #1;
        tot++; if (ch1 !== 2'd0) $display("FAIL rm_first_ch got=%0d exp=%0d", ch1, 0); else pas++;
        tot++; if (o1 !== 8'h11) $display("FAIL rm_first_data got=%h exp=%h", o1, 8'h11); else pas++;
        tot++; if (ov1 !== 1'b1) $display("FAIL rm_first_valid got=%b exp=%b", ov1, 1'b1); else pas++;
        v1 = 4'h0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_pressure();
        test_round_robin();
        test_fixed_priority();
        test_reset_midop();
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end

endmodule
